seven_segment_capture: RTL
==========================

// Module: seven_segment_capture
// PURPOSE
//  Receiving end of the multiplexed 7-seg scan interface: watches the anode select a[3:0]
//  and digit nibble d[3:0] produced by seven_segment_driver and rebuilds the 16-bit value.
//  Sits beside the display path as an on-chip monitor/self-check.
//  Frame alignment, ordering check, stability qualification and loss-of-scan timeout.
// PARAMETERS
//  TIMEOUT   1024  clk cycles without a sample strobe before the link is declared lost
//  STABLE_N  2     consecutive identical complete frames required to assert q_valid (>=1)
// PORTS
//  clk         in   1   system clock; all state on rising edge
//  rst         in   1   asynchronous, active-low reset (0 = reset)
//  clk_div     in   1   scan clock from the driver (level signal, synchronous to clk)
//  a           in   4   anode select, one-hot active-low; 4'b1110 = digit 0 (q[3:0])
//  d           in   4   hex nibble for the currently selected digit
//  q           out  16  last complete frame; digit k occupies q[4k+3:4k]
//  q_valid     out  1   high while STABLE_N identical frames have been seen and no timeout
//  frame_done  out  1   one-cycle pulse when q is updated
//  err         out  1   one-cycle pulse on an illegal or out-of-order anode sample
// BEHAVIOUR
//  Reset (rst=0, async): q=0, q_valid=0, frame_done=0, err=0, state=SYNC, shadow=0,
//   match count=0, timeout count=0, cd_q=0.
//  Strobe: cd_q <= clk_div each cycle; strobe = cd_q & ~clk_div (falling edge of clk_div,
//   mid scan slot, away from the driver's update edge). a,d sampled in the strobe cycle.
//  Legal a values: 1110,1101,1011,0111 (digit 0..3). Anything else is illegal.
//  FSM states:
//   SYNC    : ignore samples until a=1110; then shadow[3:0]<=d, exp<=1, go COLLECT.
//             Illegal a in SYNC -> err pulse, stay SYNC.
//   COLLECT : a == digit exp -> shadow nibble exp <= d, exp<=exp+1.
//             a == digit exp-1 (repeat of previous digit) -> overwrite that nibble, no err.
//             any other value (illegal or skipped/out of order) -> err pulse, go SYNC,
//             shadow discarded, match count <= 0, q unchanged.
//             digit 3 accepted -> COMMIT.
//   COMMIT  : single cycle: q <= shadow, frame_done=1; if shadow == previous q then
//             match count <= min(count+1, STABLE_N) else match count <= 1;
//             back to SYNC. A strobe falling in COMMIT is evaluated in SYNC next cycle.
//  Latency: frame_done/q update 2 clk cycles after the strobe cycle sampling digit 3.
//  q_valid = (match count >= STABLE_N), updated in COMMIT cycle (same edge as q);
//   with STABLE_N=1 it rises on the first complete frame.
//  Timeout: counter clears on every strobe, else increments (saturates). On reaching
//   TIMEOUT: q_valid<=0, match count<=0, state<=SYNC, q holds. Strobe in the same
//   cycle as terminal count wins (no timeout).
//  err and frame_done never assert in the same cycle; both are 0 outside their pulse cycle.
//  Reset mid-frame: everything returns to reset values immediately; partial frame lost.
// TESTING
//  1 Frame a=1110/d=4,1101/3,1011/2,0111/1 -> q=16'h1234, one frame_done pulse,
//    q_valid=0; repeat same frame -> q_valid=1 on second frame_done.
//  2 Frame 16'h1234 then 16'h1235 -> q=16'h1235, q_valid drops to 0, count=1.
//  3 After 1110 send 1011 (skip digit 1) -> err pulse, no frame_done, q holds 16'h1234;
//    next full aligned frame commits normally.
//  4 a=1100 in COLLECT -> err; same in SYNC -> err, state stays SYNC.
//  5 Digit 0 sampled twice (d=7 then d=9) before 1101 -> q[3:0]=9, no err.
//  6 Stop clk_div 1024 cycles with q_valid=1 -> q_valid=0 at cycle 1024, q unchanged;
//    rst=0 mid-frame -> all outputs 0 asynchronously, recovers after next full frames.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Rebuilds the 16-bit value from a multiplexed 7-seg scan (anode/nibble).
// Aligns frames, checks digit order, qualifies stability and detects scan loss.
module seven_segment_capture #(
  parameter int TIMEOUT  = 1024,
  parameter int STABLE_N = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic [3:0]  a,
  input  logic [3:0]  d,
  output logic [15:0] q,
  output logic        q_valid,
  output logic        frame_done,
  output logic        err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int MC_W = $clog2(STABLE_N + 1);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [MC_W-1:0] MC_MAX  = MC_W'(STABLE_N);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);

  localparam logic [1:0] S_SYNC    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      r_exp;
  logic [15:0]     r_shadow;
  logic [15:0]     r_q;
  logic            r_q_valid;
  logic            r_frame_done;
  logic            r_err;
  logic [MC_W-1:0] r_mcnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_cd_q;

  logic            w_strobe;
  logic            w_legal;
  logic [1:0]      w_dig;
  logic            w_to_hit;
  logic [MC_W-1:0] w_mc_next;

  assign w_strobe = r_cd_q & ~clk_div;
  assign w_to_hit = ~w_strobe & (r_to_cnt == TO_LAST);

  // Decode the active-low one-hot anode select into a digit index.
  always_comb begin
    w_legal = 1'b1;
    w_dig   = 2'd0;
    case (a)
      4'b1110: w_dig = 2'd0;
      4'b1101: w_dig = 2'd1;
      4'b1011: w_dig = 2'd2;
      4'b0111: w_dig = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  // Stability count for the frame being committed.
  always_comb begin
    w_mc_next = MC_ONE;
    if (r_shadow == r_q) begin
      if (r_mcnt == MC_MAX) w_mc_next = r_mcnt;
      else                  w_mc_next = r_mcnt + MC_ONE;
    end
  end

  // Scan-clock edge detector and loss-of-scan counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cd_q   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_cd_q <= clk_div;
      if (w_strobe)               r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Frame alignment FSM, shadow capture, commit and timeout recovery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_SYNC;
      r_exp        <= 2'd0;
      r_shadow     <= 16'h0;
      r_q          <= 16'h0;
      r_q_valid    <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_mcnt       <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_SYNC: begin
          if (w_strobe) begin
            if (!w_legal) begin
              r_err <= 1'b1;
            end else if (w_dig == 2'd0) begin
              r_shadow <= {12'h0, d};
              r_exp    <= 2'd1;
              r_state  <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (w_strobe) begin
            if (w_legal && w_dig == r_exp) begin
              r_shadow[{r_exp, 2'b00} +: 4] <= d;
              r_exp <= r_exp + 2'd1;
              if (r_exp == 2'd3) r_state <= S_COMMIT;
            end else if (w_legal && w_dig == r_exp - 2'd1) begin
              r_shadow[{w_dig, 2'b00} +: 4] <= d;
            end else begin
              r_err    <= 1'b1;
              r_shadow <= 16'h0;
              r_mcnt   <= '0;
              r_state  <= S_SYNC;
            end
          end
        end
        S_COMMIT: begin
          r_q          <= r_shadow;
          r_frame_done <= 1'b1;
          r_mcnt       <= w_mc_next;
          r_q_valid    <= (w_mc_next >= MC_MAX);
          r_state      <= S_SYNC;
        end
        default: r_state <= S_SYNC;
      endcase
      if (w_to_hit) begin
        r_q_valid <= 1'b0;
        r_mcnt    <= '0;
        r_state   <= S_SYNC;
      end
    end
  end

  assign q          = r_q;
  assign q_valid    = r_q_valid;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule
